// File: rtl/hex_scroll_pkg.sv
// rtl/hex_scroll_pkg.sv - shared types, constants and width helper for the HEX scroller
// Contents:
//   state_e    controller state (IDLE, LOAD, READY, RUN)
//   BLANK_SEG  active-low segment pattern with every segment off
//   ptr_w(n)   width of len/offset/wr_ptr, wide enough to hold n itself
package hex_scroll_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    READY = 2'd2,
    RUN   = 2'd3
  } state_e;

  localparam logic [6:0] BLANK_SEG = 7'h7F;

  function automatic int ptr_w(input int n);
    return $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/scroll_tick_gen.sv
// rtl/scroll_tick_gen.sv - prescaler emitting one tick every TICK_DIV enabled cycles
// Ports:
//   clk     in   1  system clock
//   reset   in   1  synchronous, active-high
//   clear   in   1  synchronous restart of the count at 0 (wins over enable)
//   enable  in   1  count advances only while high; low holds the count
//   tick    out  1  high during the enabled cycle whose count is TICK_DIV-1
module scroll_tick_gen #(
  parameter int TICK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

  logic [CW-1:0] cnt_q;
  logic          at_last;

  assign at_last = (cnt_q == CW'(TICK_DIV - 1));
  assign tick    = enable && at_last;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      cnt_q <= '0;
    end else if (enable) begin
      cnt_q <= at_last ? '0 : cnt_q + CW'(1);
    end
  end

endmodule

// File: rtl/seg7.sv
// rtl/seg7.sv - hex nibble to active-low seven-segment decoder
// Ports:
//   hex  in  4  digit value 0-F
//   seg  out 7  segments gfedcba, active-low
module seg7 (
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  always_comb begin
    seg = 7'h7F;
    case (hex)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      4'hF: seg = 7'h0E;
      default: seg = 7'h7F;
    endcase
  end

endmodule

// File: rtl/hex_scroll_ctrl.sv
// rtl/hex_scroll_ctrl.sv - scrolling message window across the six DE1-SoC HEX displays
// Ports:
//   clk        in   1  system clock
//   reset      in   1  synchronous, active-high
//   wr_valid   in   1  digit write request
//   wr_data    in   4  digit value 0-F
//   wr_last    in   1  marks the final digit of the message
//   wr_ready   out  1  high in IDLE/LOAD; write happens on wr_valid & wr_ready
//   start      in   1  pulse: begin/restart scrolling (READY/RUN only)
//   pause      in   1  level: freeze scroll position and prescaler (RUN only)
//   clr        in   1  pulse: drop message, return to IDLE
//   busy       out  1  high in RUN
//   HEX0..HEX5 out  7  active-low segments, HEX5 is the leftmost digit
module hex_scroll_ctrl
  import hex_scroll_pkg::*;
#(
  parameter int N_DIGITS = 16,
  parameter int TICK_DIV = 25_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_valid,
  input  logic [3:0] wr_data,
  input  logic       wr_last,
  output logic       wr_ready,
  input  logic       start,
  input  logic       pause,
  input  logic       clr,
  output logic       busy,
  output logic [6:0] HEX0,
  output logic [6:0] HEX1,
  output logic [6:0] HEX2,
  output logic [6:0] HEX3,
  output logic [6:0] HEX4,
  output logic [6:0] HEX5
);

  localparam int PW = ptr_w(N_DIGITS);

  state_e        state_q, state_d;
  logic [PW-1:0] len_q, wr_ptr_q, offset_q;
  logic [3:0]    msg_buf [N_DIGITS];

  logic wr_fire, load_done, start_ok, tick, tick_clear, tick_en;

  // clr outranks start and writes; start only has meaning once a message is complete
  assign wr_fire   = wr_valid && wr_ready && !clr;
  assign load_done = wr_fire && (wr_last || (wr_ptr_q == PW'(N_DIGITS - 1)));
  assign start_ok  = start && !clr && ((state_q == READY) || (state_q == RUN));

  // prescaler sits at 0 outside RUN so every run begins with a full interval
  assign tick_clear = (state_q != RUN) || start_ok || clr;
  assign tick_en    = (state_q == RUN) && !pause;

  scroll_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk    (clk),
    .reset  (reset),
    .clear  (tick_clear),
    .enable (tick_en),
    .tick   (tick)
  );

  // state register
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // next state; IDLE and LOAD share logic because wr_ptr is 0 in IDLE,
  // which makes a single wr_last write land in READY with len=1
  always_comb begin
    state_d = state_q;
    if (clr) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE, LOAD: if (wr_fire) state_d = load_done ? READY : LOAD;
        READY:      if (start_ok) state_d = RUN;
        RUN:        state_d = RUN;
        default:    state_d = IDLE;
      endcase
    end
  end

  // state-decoded outputs
  always_comb begin
    wr_ready = (state_q == IDLE) || (state_q == LOAD);
    busy     = (state_q == RUN);
  end

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      len_q    <= '0;
      wr_ptr_q <= '0;
      offset_q <= '0;
    end else begin
      if (wr_fire) begin
        wr_ptr_q <= wr_ptr_q + PW'(1);
        if (load_done) len_q <= wr_ptr_q + PW'(1);
      end
      if (start_ok) begin
        offset_q <= '0;
      end else if ((state_q == RUN) && tick && (len_q > PW'(6))) begin
        offset_q <= (offset_q + PW'(1) == len_q) ? '0 : offset_q + PW'(1);
      end
    end
  end

  // message storage has no reset; len=0 already hides any stale contents
  always_ff @(posedge clk) begin
    for (int j = 0; j < N_DIGITS; j++) begin
      if (!reset && wr_fire && (wr_ptr_q == PW'(j))) msg_buf[j] <= wr_data;
    end
  end

  // Window position k (0 = HEX5). offset < len and k < 6 < len, so one
  // conditional subtract is enough for the circular wrap. With len <= 6 the
  // offset is always 0 and positions at or past len are blank (also covers len=0).
  logic [PW-1:0] sum_c  [6];
  logic [PW-1:0] idx_c  [6];
  logic [3:0]    digit_c[6];
  logic [5:0]    blank_c;

  always_comb begin
    for (int k = 0; k < 6; k++) begin
      sum_c[k]   = offset_q + PW'(k);
      idx_c[k]   = (sum_c[k] >= len_q) ? sum_c[k] - len_q : sum_c[k];
      blank_c[k] = (len_q <= PW'(6)) && (PW'(k) >= len_q);
      digit_c[k] = 4'h0;
      for (int j = 0; j < N_DIGITS; j++) begin
        if (idx_c[k] == PW'(j)) digit_c[k] = msg_buf[j];
      end
    end
  end

  logic [3:0] digit_q [6];
  logic [5:0] blank_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      blank_q <= '1;
      for (int k = 0; k < 6; k++) digit_q[k] <= 4'h0;
    end else begin
      blank_q <= blank_c;
      for (int k = 0; k < 6; k++) digit_q[k] <= digit_c[k];
    end
  end

  logic [6:0] seg_raw [6];
  logic [6:0] win_seg [6];

  for (genvar g = 0; g < 6; g++) begin : g_dig
    seg7 u_seg7 (
      .hex (digit_q[g]),
      .seg (seg_raw[g])
    );
  end

  always_comb begin
    for (int k = 0; k < 6; k++) begin
      win_seg[k] = blank_q[k] ? BLANK_SEG : seg_raw[k];
    end
  end

  assign HEX5 = win_seg[0];
  assign HEX4 = win_seg[1];
  assign HEX3 = win_seg[2];
  assign HEX2 = win_seg[3];
  assign HEX1 = win_seg[4];
  assign HEX0 = win_seg[5];

endmodule

// File: tb/tb_hex_scroll_ctrl.sv
// tb/tb_hex_scroll_ctrl.sv - self-checking bench for hex_scroll_ctrl
module tb_hex_scroll_ctrl;

  logic       clk = 1'b0;
  logic       reset, wr_valid, wr_last, start, pause, clr;
  logic [3:0] wr_data;
  logic       wr_ready, busy;
  logic [6:0] HEX0, HEX1, HEX2, HEX3, HEX4, HEX5;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  hex_scroll_ctrl #(.N_DIGITS(16), .TICK_DIV(4)) dut (
    .clk(clk), .reset(reset),
    .wr_valid(wr_valid), .wr_data(wr_data), .wr_last(wr_last), .wr_ready(wr_ready),
    .start(start), .pause(pause), .clr(clr), .busy(busy),
    .HEX0(HEX0), .HEX1(HEX1), .HEX2(HEX2), .HEX3(HEX3), .HEX4(HEX4), .HEX5(HEX5)
  );

  logic [6:0] seg_tab [16];
  localparam logic [6:0] BL = 7'h7F;

  typedef struct {
    int          n;
    logic [63:0] digs;
    logic [41:0] exp;   // {HEX5, HEX4, HEX3, HEX2, HEX1, HEX0}
  } vec_t;

  vec_t vecs [4];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_hex(input string tag, input logic [41:0] exp);
    chk({tag, " HEX5"}, 32'(HEX5), 32'(exp[41:35]));
    chk({tag, " HEX4"}, 32'(HEX4), 32'(exp[34:28]));
    chk({tag, " HEX3"}, 32'(HEX3), 32'(exp[27:21]));
    chk({tag, " HEX2"}, 32'(HEX2), 32'(exp[20:14]));
    chk({tag, " HEX1"}, 32'(HEX1), 32'(exp[13:7]));
    chk({tag, " HEX0"}, 32'(HEX0), 32'(exp[6:0]));
  endtask

  // expected window for a len>6 message whose digit i equals i
  function automatic logic [41:0] scroll_exp(input int off, input int len);
    logic [41:0] e;
    for (int k = 0; k < 6; k++) e[41 - 7*k -: 7] = seg_tab[(off + k) % len];
    return e;
  endfunction

  task automatic write_msg(input int n, input logic [63:0] digs, input bit use_last);
    for (int i = 0; i < n; i++) begin
      wr_valid = 1'b1;
      wr_data  = digs[4*i +: 4];
      wr_last  = use_last && (i == n - 1);
      chk($sformatf("wr_ready write %0d", i), 32'(wr_ready), 32'd1);
      step();
    end
    wr_valid = 1'b0;
    wr_last  = 1'b0;
  endtask

  task automatic do_clr();
    clr = 1'b1;
    step();
    clr = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1);
  end

  initial begin
    seg_tab[0]  = 7'h40; seg_tab[1]  = 7'h79; seg_tab[2]  = 7'h24; seg_tab[3]  = 7'h30;
    seg_tab[4]  = 7'h19; seg_tab[5]  = 7'h12; seg_tab[6]  = 7'h02; seg_tab[7]  = 7'h78;
    seg_tab[8]  = 7'h00; seg_tab[9]  = 7'h10; seg_tab[10] = 7'h08; seg_tab[11] = 7'h03;
    seg_tab[12] = 7'h46; seg_tab[13] = 7'h21; seg_tab[14] = 7'h06; seg_tab[15] = 7'h0E;

    vecs[0] = '{1, 64'hA,       {7'h08, BL,    BL,    BL,    BL,    BL   }};
    vecs[1] = '{3, 64'h321,     {7'h79, 7'h24, 7'h30, BL,    BL,    BL   }};
    vecs[2] = '{6, 64'hABCDEF,  {7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08}};
    vecs[3] = '{7, 64'h6543210, {7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12}};

    reset = 1'b1; wr_valid = 1'b0; wr_data = 4'h0; wr_last = 1'b0;
    start = 1'b0; pause = 1'b0; clr = 1'b0;

    // reset state
    step(); step();
    check_hex("reset", {6{BL}});
    chk("reset wr_ready", 32'(wr_ready), 32'd1);
    chk("reset busy", 32'(busy), 32'd0);
    reset = 1'b0;

    // start while IDLE is ignored
    do_start();
    chk("idle start busy", 32'(busy), 32'd0);

    // static windows after loading
    for (int v = 0; v < 4; v++) begin
      do_clr();
      write_msg(vecs[v].n, vecs[v].digs, 1'b1);
      chk($sformatf("vec%0d ready wr_ready", v), 32'(wr_ready), 32'd0);
      chk($sformatf("vec%0d ready busy", v), 32'(busy), 32'd0);
      step();
      check_hex($sformatf("vec%0d window", v), vecs[v].exp);
    end

    // short message does not scroll while running
    do_clr();
    write_msg(3, 64'h321, 1'b1);
    do_start();
    chk("short run busy", 32'(busy), 32'd1);
    for (int t = 1; t <= 40; t++) begin
      step();
      if (t % 8 == 0) check_hex($sformatf("short t%0d", t), vecs[1].exp);
    end

    // nine digit message scrolls one step per four cycles, wrapping
    do_clr();
    write_msg(9, 64'h876543210, 1'b1);
    do_start();
    for (int t = 1; t <= 40; t++) begin
      step();
      check_hex($sformatf("scroll9 t%0d", t), scroll_exp(((t - 1) / 4) % 9, 9));
    end

    // pause mid-count freezes both window and prescaler
    do_clr();
    write_msg(9, 64'h876543210, 1'b1);
    do_start();
    step(); step();
    pause = 1'b1;
    for (int t = 0; t < 10; t++) begin
      step();
      chk($sformatf("pause hold HEX5 %0d", t), 32'(HEX5), 32'(seg_tab[0]));
    end
    pause = 1'b0;
    step();
    chk("resume +1 HEX5", 32'(HEX5), 32'(seg_tab[0]));
    step();
    chk("resume +2 HEX5", 32'(HEX5), 32'(seg_tab[0]));
    step();
    chk("resume +3 HEX5", 32'(HEX5), 32'(seg_tab[1]));
    chk("resume +3 HEX0", 32'(HEX0), 32'(seg_tab[6]));

    // full buffer without wr_last closes the message at sixteen digits
    do_clr();
    write_msg(16, 64'hFEDCBA9876543210, 1'b0);
    chk("full wr_ready", 32'(wr_ready), 32'd0);
    chk("full busy", 32'(busy), 32'd0);
    wr_valid = 1'b1; wr_data = 4'h7;
    step();
    wr_valid = 1'b0;
    check_hex("full ready window", scroll_exp(0, 16));
    do_start();
    for (int t = 1; t <= 45; t++) step();
    check_hex("full offset11", scroll_exp(11, 16));

    // clr and start together: clr wins
    clr = 1'b1; start = 1'b1;
    step();
    clr = 1'b0; start = 1'b0;
    chk("clr+start busy", 32'(busy), 32'd0);
    chk("clr+start wr_ready", 32'(wr_ready), 32'd1);
    step();
    check_hex("clr+start blank", {6{BL}});

    // reset mid-run
    write_msg(9, 64'h876543210, 1'b1);
    do_start();
    for (int t = 0; t < 6; t++) step();
    chk("pre-reset busy", 32'(busy), 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("midrun reset busy", 32'(busy), 32'd0);
    chk("midrun reset wr_ready", 32'(wr_ready), 32'd1);
    check_hex("midrun reset", {6{BL}});
    step();
    check_hex("after reset", {6{BL}});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
